// File: rtl/mem_bus_arb2.sv
// Two-master arbiter for the single valid/ready sys_sdram port: one transaction
// in flight at a time, registered response, timeout abort with a sticky error.
module mem_bus_arb2 #(
  parameter bit          RR       = 1'b1,
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        err,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pick;
  req_t             m0_req, m1_req, req_d;
  logic             s_valid_d, m0_ready_d, m1_ready_d, err_d;
  logic [DW-1:0]    m0_rdata_d, m1_rdata_d;
  logic [AW-1:0]    err_addr_d;

  assign m0_req = {m0_addr, m0_wdata, m0_wstrb};
  assign m1_req = {m1_addr, m1_wdata, m1_wstrb};

  // Next-state, grant selection and next values of every registered output
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    pick       = 1'b0;
    req_d      = {s_addr, s_wdata, s_wstrb};
    s_valid_d  = s_valid;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    m0_rdata_d = m0_rdata;
    m1_rdata_d = m1_rdata;
    err_d      = err;
    err_addr_d = err_addr;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          // Tie goes to the master not granted last (RR) or always master 0
          pick      = (m0_valid && m1_valid) ? (RR ? ~last_q : 1'b0) : m1_valid;
          grant_d   = pick;
          last_d    = pick;
          req_d     = pick ? m1_req : m0_req;
          s_valid_d = 1'b1;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (s_ready) begin
          s_valid_d = 1'b0;
          state_d   = RESP;
          if (grant_q) begin
            m1_rdata_d = s_rdata;
            m1_ready_d = 1'b1;
          end else begin
            m0_rdata_d = s_rdata;
            m0_ready_d = 1'b1;
          end
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          s_valid_d = 1'b0;
          state_d   = RESP;
          if (grant_q) begin
            m1_rdata_d = ERR_DATA;
            m1_ready_d = 1'b1;
          end else begin
            m0_rdata_d = ERR_DATA;
            m0_ready_d = 1'b1;
          end
          if (!err) begin
            err_d      = 1'b1;
            err_addr_d = s_addr;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A clear wins over a timeout setting the flag in the same cycle
    if (err_clr) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      s_valid  <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_wstrb  <= '0;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      s_valid  <= s_valid_d;
      s_addr   <= req_d.addr;
      s_wdata  <= req_d.wdata;
      s_wstrb  <= req_d.wstrb;
      m0_ready <= m0_ready_d;
      m1_ready <= m1_ready_d;
      m0_rdata <= m0_rdata_d;
      m1_rdata <= m1_rdata_d;
      err      <= err_d;
      err_addr <= err_addr_d;
    end
  end

endmodule
